// File: rtl/vga_sig_pkg.sv
// Shared types and CRC constants for the VGA frame signature checker.
package vga_sig_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACTIVE,
    S_DONE
  } sig_state_t;

  // CRC-32/MPEG-2: non-reflected, MSB-first, no final XOR
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_parallel.sv
// Combinational next-state of a CRC-32/MPEG-2 register after absorbing DATA_W bits,
// most significant data bit first.
module crc32_parallel
  import vga_sig_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic [31:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [31:0]       crc_out
);

  // Unrolled bit-serial LFSR; each iteration folds in one data bit
  always_comb begin
    crc_out = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (crc_out[31] ^ data[i]) crc_out = {crc_out[30:0], 1'b0} ^ CRC_POLY;
      else                       crc_out = {crc_out[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/vga_frame_signature.sv
// Folds in-window pixels of each VGA frame into a CRC-32 signature, compares it
// against a reference and keeps saturating frame and mismatch counters.
module vga_frame_signature
  import vga_sig_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int CH_WIDTH    = 8,
  parameter int VIEW_LEFT   = 160,
  parameter int VIEW_TOP    = 120,
  parameter int VIEW_WIDTH  = 320,
  parameter int VIEW_HEIGHT = 240,
  parameter int CNT_W       = 16
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic                         Vsync_i,
  input  logic                         Pixel_en_i,
  input  logic [9:0]                   Pixel_X_i,
  input  logic [9:0]                   Pixel_Y_i,
  input  logic [CHANNELS*CH_WIDTH-1:0] Pixel_data_i,
  input  logic                         Start_i,
  input  logic                         Continuous_i,
  input  logic [31:0]                  Expected_sig_i,
  output logic [31:0]                  Sig_o,
  output logic                         Sig_valid_o,
  output logic                         Match_o,
  output logic                         Short_frame_o,
  output logic [CNT_W-1:0]             Mismatch_count_o,
  output logic [CNT_W-1:0]             Frame_count_o,
  output logic                         Busy_o
);

  localparam int DW    = CHANNELS * CH_WIDTH;
  localparam int NPIX  = VIEW_WIDTH * VIEW_HEIGHT;
  localparam int PIX_W = $clog2(NPIX + 1);
  localparam logic [PIX_W-1:0] NPIX_V = PIX_W'(NPIX);

  // Window bounds widened by one bit so LEFT+WIDTH can reach 1024
  localparam logic [10:0] X_LO = 11'(VIEW_LEFT);
  localparam logic [10:0] X_HI = 11'(VIEW_LEFT + VIEW_WIDTH);
  localparam logic [10:0] Y_LO = 11'(VIEW_TOP);
  localparam logic [10:0] Y_HI = 11'(VIEW_TOP + VIEW_HEIGHT);

  sig_state_t       state, state_nx;
  logic             vs_q, cont_q;
  logic [31:0]      crc, crc_nx;
  logic [PIX_W-1:0] pix_cnt;
  logic             frame_start, frame_end, in_window, pix_ok, ok;

  assign frame_start = Vsync_i & ~vs_q;
  assign frame_end   = ~Vsync_i & vs_q;
  assign in_window   = Pixel_en_i
                    && ({1'b0, Pixel_X_i} >= X_LO) && ({1'b0, Pixel_X_i} < X_HI)
                    && ({1'b0, Pixel_Y_i} >= Y_LO) && ({1'b0, Pixel_Y_i} < Y_HI);
  assign pix_ok      = (pix_cnt == NPIX_V);
  assign ok          = (crc == Expected_sig_i) && pix_ok;

  // The one-cycle S_DONE gap between continuous frames still counts as busy
  assign Busy_o = (state == S_ARMED) || (state == S_ACTIVE) || ((state == S_DONE) && cont_q);

  crc32_parallel #(.DATA_W(DW)) u_crc (
    .crc_in  (crc),
    .data    (Pixel_data_i),
    .crc_out (crc_nx)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (Start_i)     state_nx = S_ARMED;
      S_ARMED:  if (frame_start) state_nx = S_ACTIVE;
      S_ACTIVE: if (frame_end)   state_nx = S_DONE;
      S_DONE:   state_nx = cont_q ? S_ARMED : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      vs_q             <= 1'b0;
      cont_q           <= 1'b0;
      crc              <= '0;
      pix_cnt          <= '0;
      Sig_o            <= '0;
      Sig_valid_o      <= 1'b0;
      Match_o          <= 1'b0;
      Short_frame_o    <= 1'b0;
      Mismatch_count_o <= '0;
      Frame_count_o    <= '0;
    end else begin
      vs_q        <= Vsync_i;
      Sig_valid_o <= 1'b0;
      case (state)
        S_IDLE: if (Start_i) begin
          cont_q           <= Continuous_i;
          Short_frame_o    <= 1'b0;
          Mismatch_count_o <= '0;
          Frame_count_o    <= '0;
        end
        S_ARMED: if (frame_start) begin
          crc     <= CRC_INIT;
          pix_cnt <= '0;
        end
        S_ACTIVE: if (in_window) begin
          crc <= crc_nx;
          if (pix_cnt != '1) pix_cnt <= pix_cnt + PIX_W'(1);
        end
        S_DONE: begin
          Sig_o       <= crc;
          Sig_valid_o <= 1'b1;
          Match_o     <= ok;
          if (Frame_count_o != '1) Frame_count_o <= Frame_count_o + CNT_W'(1);
          if (!ok && (Mismatch_count_o != '1)) Mismatch_count_o <= Mismatch_count_o + CNT_W'(1);
          if (!pix_ok) Short_frame_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_signature.sv
// Randomised scoreboard bench for vga_frame_signature on a small synthetic frame,
// plus a 1x1 single-channel instance for the known CRC-32/MPEG-2 vector.
module tb_vga_frame_signature;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int WL = 3;
  localparam int WT = 2;
  localparam int WW = 5;
  localparam int WH = 4;
  localparam int NPIX = WW * WH;
  localparam int SYNC = 4;
  localparam int CNT_MAX = 3;
  localparam int CORRUPT_K = 3 * COLS + 4;
  localparam logic [31:0] VEC_SIG = 32'h4E08BFB4;

  logic        clock = 1'b0;
  logic        resetn;
  logic        vsync;
  logic        pixel_en;
  logic [9:0]  pixel_x, pixel_y;
  logic [23:0] pixel_data;
  logic        start, continuous;
  logic [31:0] expected_sig;

  logic [31:0] sig;
  logic        sig_valid, match, short_frame, busy;
  logic [1:0]  mismatch_count, frame_count;

  logic [31:0] v_sig;
  logic        v_valid, v_match, v_short, v_busy;
  logic [15:0] v_mismatch, v_frames;

  typedef struct {
    logic [31:0] sig;
    logic        match;
    int          fc;
    int          mc;
    logic        shortf;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          mdl_fc, mdl_mc;
  bit          mdl_short;
  logic [31:0] crc_tab[256];
  logic        prev_valid = 1'b0;

  always #10 clock = ~clock;

  vga_frame_signature #(
    .CHANNELS(3), .CH_WIDTH(8), .VIEW_LEFT(WL), .VIEW_TOP(WT),
    .VIEW_WIDTH(WW), .VIEW_HEIGHT(WH), .CNT_W(2)
  ) dut (
    .Clock(clock), .Resetn(resetn), .Vsync_i(vsync), .Pixel_en_i(pixel_en),
    .Pixel_X_i(pixel_x), .Pixel_Y_i(pixel_y), .Pixel_data_i(pixel_data),
    .Start_i(start), .Continuous_i(continuous), .Expected_sig_i(expected_sig),
    .Sig_o(sig), .Sig_valid_o(sig_valid), .Match_o(match), .Short_frame_o(short_frame),
    .Mismatch_count_o(mismatch_count), .Frame_count_o(frame_count), .Busy_o(busy)
  );

  vga_frame_signature #(
    .CHANNELS(1), .CH_WIDTH(8), .VIEW_LEFT(WL), .VIEW_TOP(WT),
    .VIEW_WIDTH(1), .VIEW_HEIGHT(1), .CNT_W(16)
  ) dut_vec (
    .Clock(clock), .Resetn(resetn), .Vsync_i(vsync), .Pixel_en_i(pixel_en),
    .Pixel_X_i(pixel_x), .Pixel_Y_i(pixel_y), .Pixel_data_i(pixel_data[23:16]),
    .Start_i(start), .Continuous_i(continuous), .Expected_sig_i(VEC_SIG),
    .Sig_o(v_sig), .Sig_valid_o(v_valid), .Match_o(v_match), .Short_frame_o(v_short),
    .Mismatch_count_o(v_mismatch), .Frame_count_o(v_frames), .Busy_o(v_busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte-table CRC-32/MPEG-2; a pixel is three bytes, red first
  function automatic logic [31:0] crcPixel(input logic [31:0] crc, input logic [23:0] px);
    logic [31:0] c;
    logic [7:0]  b;
    c = crc;
    for (int ch = 0; ch < 3; ch++) begin
      b = px[23 - 8*ch -: 8];
      c = (c << 8) ^ crc_tab[c[31:24] ^ b];
    end
    return c;
  endfunction

  function automatic bit inWin(input int c, input int r);
    return (c >= WL) && (c < WL + WW) && (r >= WT) && (r < WT + WH);
  endfunction

  function automatic void clearModel();
    mdl_fc = 0;
    mdl_mc = 0;
    mdl_short = 0;
  endfunction

  function automatic void pushExpect(input logic [31:0] crc, input bit ok, input int cnt);
    if (mdl_fc < CNT_MAX) mdl_fc++;
    if (!ok && mdl_mc < CNT_MAX) mdl_mc++;
    if (cnt != NPIX) mdl_short = 1;
    sb.push_back('{crc, ok, mdl_fc, mdl_mc, mdl_short});
  endfunction

  task automatic startDut(input bit cont);
    start = 1'b1;
    continuous = cont;
    tick();
    start = 1'b0;
    continuous = 1'($urandom_range(0, 1));
    clearModel();
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // One frame: Vsync rise, raster with random idle gaps, Vsync fall, junk during sync.
  // exp_mode: 0 = clean-frame CRC, 1 = CRC of driven pixels, 2 = deliberately wrong.
  task automatic applyStimulus(input bit zero, input int corrupt, input bit drop_last,
                               input bit same_end, input int exp_mode, input bit checked,
                               input int start_at, input int abort_at);
    logic [23:0] clean[ROWS][COLS];
    logic [23:0] drv[ROWS][COLS];
    logic [31:0] crc_clean, crc_act, exp_v;
    int          cnt, k;
    bit          ok, aborted, last;
    crc_clean = 32'hFFFFFFFF;
    crc_act   = 32'hFFFFFFFF;
    cnt = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        clean[r][c] = zero ? 24'd0 : 24'($urandom);
        drv[r][c] = clean[r][c];
        if (r * COLS + c == corrupt) drv[r][c] = drv[r][c] ^ (24'd1 << $urandom_range(0, 23));
        if (inWin(c, r)) begin
          crc_clean = crcPixel(crc_clean, clean[r][c]);
          if (!(drop_last && r == ROWS - 1 && c == COLS - 1)) begin
            crc_act = crcPixel(crc_act, drv[r][c]);
            cnt++;
          end
        end
      end
    case (exp_mode)
      0:       exp_v = crc_clean;
      1:       exp_v = crc_act;
      default: exp_v = crc_clean ^ 32'h1;
    endcase
    ok = (crc_act == exp_v) && (cnt == NPIX);
    expected_sig = exp_v;

    vsync = 1'b1;
    pixel_en = 1'b0;
    tick();
    aborted = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        k = r * COLS + c;
        if (aborted) continue;
        if (k == abort_at) begin
          resetn = 1'b0;
          tick();
          resetn = 1'b1;
          aborted = 1;
          continue;
        end
        if (k == start_at) begin
          pixel_en = 1'b0;
          start = 1'b1;
          continuous = 1'b0;
          tick();
          start = 1'b0;
          clearModel();
        end
        if ($urandom_range(0, 1) == 1) begin
          pixel_en = 1'b0;
          pixel_x = 10'(WL + $urandom_range(0, WW - 1));
          pixel_y = 10'(WT + $urandom_range(0, WH - 1));
          pixel_data = 24'($urandom);
          tick();
        end
        last = (r == ROWS - 1) && (c == COLS - 1);
        pixel_en = !(drop_last && last);
        pixel_x = 10'(c);
        pixel_y = 10'(r);
        pixel_data = drv[r][c];
        if (same_end && last) begin
          vsync = 1'b0;
          if (checked) pushExpect(crc_act, ok, cnt);
        end
        tick();
      end
    pixel_en = 1'b0;
    if (!aborted && !same_end) begin
      vsync = 1'b0;
      if (checked) pushExpect(crc_act, ok, cnt);
      tick();
    end
    vsync = 1'b0;
    repeat (SYNC) begin
      pixel_en = 1'b1;
      pixel_x = 10'(WL + $urandom_range(0, WW - 1));
      pixel_y = 10'(WT + $urandom_range(0, WH - 1));
      pixel_data = 24'($urandom);
      tick();
    end
    pixel_en = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every Sig_valid_o pulse consumes one expected frame result
  always @(negedge clock) begin
    if (sig_valid === 1'b1) begin
      checkOutput("valid_width", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got pulse with sig 0x%08h expected no pulse", sig);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sig", sig, mon_e.sig);
        checkOutput("match", 32'(match), 32'(mon_e.match));
        checkOutput("frame_count", 32'(frame_count), 32'(mon_e.fc));
        checkOutput("mismatch_count", 32'(mismatch_count), 32'(mon_e.mc));
        checkOutput("short_frame", 32'(short_frame), 32'(mon_e.shortf));
      end
    end
    prev_valid = sig_valid;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] t;
    for (int i = 0; i < 256; i++) begin
      t = 32'(i) << 24;
      for (int b = 0; b < 8; b++) t = t[31] ? ((t << 1) ^ 32'h04C11DB7) : (t << 1);
      crc_tab[i] = t;
    end
    clearModel();
    resetn = 1'b0;
    vsync = 1'b0;
    pixel_en = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    pixel_data = '0;
    start = 1'b0;
    continuous = 1'b0;
    expected_sig = '0;
    repeat (3) tick();

    checkOutput("rst_sig", sig, 32'd0);
    checkOutput("rst_valid", 32'(sig_valid), 32'd0);
    checkOutput("rst_match", 32'(match), 32'd0);
    checkOutput("rst_short", 32'(short_frame), 32'd0);
    checkOutput("rst_frames", 32'(frame_count), 32'd0);
    checkOutput("rst_mismatch", 32'(mismatch_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_vec_sig", v_sig, 32'd0);
    resetn = 1'b1;
    tick();

    $display("[TB] known vector: single zero pixel");
    startDut(0);
    applyStimulus(1, -1, 0, 0, 0, 1, -1, -1);
    checkOutput("vec_sig", v_sig, VEC_SIG);
    checkOutput("vec_match", 32'(v_match), 32'd1);
    checkOutput("vec_frames", 32'(v_frames), 32'd1);
    checkOutput("vec_mismatch", 32'(v_mismatch), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_vec_busy", 32'(v_busy), 32'd0);

    $display("[TB] single-shot frames: clean, last pixel on vsync edge, corrupted");
    startDut(0);
    applyStimulus(0, -1, 0, 0, 0, 1, -1, -1);
    startDut(0);
    applyStimulus(0, -1, 0, 1, 0, 1, -1, -1);
    startDut(0);
    applyStimulus(0, CORRUPT_K, 0, 0, 0, 1, -1, -1);

    $display("[TB] continuous: three frames, middle one corrupted");
    startDut(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, (i == 1) ? CORRUPT_K : -1, 0, i == 2, 0, 1, -1, -1);
      checkOutput("cont_busy", 32'(busy), 32'd1);
    end

    $display("[TB] reset pulse mid-frame");
    applyStimulus(0, -1, 0, 0, 0, 0, -1, 6);
    clearModel();
    checkOutput("mrst_sig", sig, 32'd0);
    checkOutput("mrst_match", 32'(match), 32'd0);
    checkOutput("mrst_short", 32'(short_frame), 32'd0);
    checkOutput("mrst_frames", 32'(frame_count), 32'd0);
    checkOutput("mrst_mismatch", 32'(mismatch_count), 32'd0);
    checkOutput("mrst_busy", 32'(busy), 32'd0);

    $display("[TB] arm mid-frame, only the following full frame is checked");
    applyStimulus(0, -1, 0, 0, 0, 0, 5, -1);
    applyStimulus(0, -1, 0, 0, 0, 1, -1, -1);

    $display("[TB] short frame with matching crc");
    startDut(0);
    applyStimulus(0, -1, 1, 0, 1, 1, -1, -1);

    $display("[TB] counter saturation: five mismatching continuous frames");
    startDut(1);
    repeat (5) applyStimulus(0, -1, 0, 1'($urandom_range(0, 1)), 2, 1, -1, -1);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
